// File: rtl/ififo_ctrl.sv
// ififo_ctrl: loads weight vectors from SRAM into the input FIFO bank, then drains them to the MAC array.
module ififo_ctrl #(
   parameter int row    = 8,
   parameter int bw     = 4,
   parameter int addr_w = 11,
   parameter int rd_lat = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [addr_w-1:0] base_addr,
   input  logic [6:0]        num_vec,
   output logic              mem_cen,
   output logic [addr_w-1:0] mem_addr,
   input  logic [row*bw-1:0] mem_rdata,
   output logic [row*bw-1:0] fifo_in,
   output logic [row-1:0]    fifo_wr,
   input  logic              fifo_full,
   input  logic              fifo_valid,
   output logic              fifo_rd,
   input  logic              mac_ready,
   output logic              mac_valid,
   output logic              busy,
   output logic              done
);
   typedef enum logic [2:0] {IDLE, LOAD, FLUSH, DRAIN, DONE} state_t;
   state_t            state_q, state_d;
   logic [addr_w-1:0] base_q, base_d;
   logic [6:0]        n_q, n_d, iss_q, iss_d, wr_q, wr_d, rd_q, rd_d;
   logic              pend_q, pend_d, skid_v_q, skid_v_d, done_q, done_d;
   logic [row*bw-1:0] skid_q, skid_d;
   logic [rd_lat-1:0] dl_q, dl_d;
   logic              issue, wr;
   always_comb begin
      issue     = state_q == LOAD && !fifo_full && !skid_v_q && iss_q < n_q;
      // pend_q marks a read issued last cycle whose data is on mem_rdata now
      wr        = (pend_q || skid_v_q) && !fifo_full;
      fifo_rd   = state_q == DRAIN && mac_ready && fifo_valid && rd_q < n_q;
      mem_cen   = !issue;
      mem_addr  = issue ? base_q + addr_w'(iss_q) : '0;
      fifo_wr   = {row{wr}};
      fifo_in   = !wr ? '0 : skid_v_q ? skid_q : mem_rdata;
      mac_valid = dl_q[rd_lat-1];
      busy      = state_q != IDLE;
      done      = done_q;
      pend_d    = issue;
      skid_v_d  = fifo_full && (pend_q || skid_v_q);
      skid_d    = pend_q && fifo_full ? mem_rdata : skid_q;
      iss_d     = iss_q + 7'(issue);
      wr_d      = wr_q + 7'(wr);
      rd_d      = rd_q + 7'(fifo_rd);
      dl_d      = rd_lat'({dl_q, fifo_rd});
      done_d    = state_q == DONE;
      base_d    = base_q;
      n_d       = n_q;
      state_d   = state_q;
      unique case (state_q)
         IDLE: if (start) begin
            base_d  = base_addr;
            n_d     = num_vec > 7'd64 ? 7'd64 : num_vec;
            iss_d   = '0;
            wr_d    = '0;
            rd_d    = '0;
            state_d = num_vec == 7'd0 ? DONE : LOAD;
         end
         LOAD:  state_d = iss_d == n_q ? FLUSH : LOAD;
         FLUSH: state_d = wr_q == n_q ? DRAIN : FLUSH;
         DRAIN: state_d = rd_q == n_q && dl_q == '0 ? DONE : DRAIN;
         DONE:  state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         base_q   <= '0;
         n_q      <= '0;
         iss_q    <= '0;
         wr_q     <= '0;
         rd_q     <= '0;
         pend_q   <= 1'b0;
         skid_v_q <= 1'b0;
         skid_q   <= '0;
         dl_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         n_q      <= n_d;
         iss_q    <= iss_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         pend_q   <= pend_d;
         skid_v_q <= skid_v_d;
         skid_q   <= skid_d;
         dl_q     <= dl_d;
         done_q   <= done_d;
      end
   end
endmodule

// File: tb/tb_ififo_ctrl.sv
// tb_ififo_ctrl: directed tiles against an SRAM/FIFO environment and an ordering/count scoreboard.
module tb_ififo_ctrl;
   logic        clk = 0, reset = 0, start = 0;
   logic [10:0] base_addr = '0;
   logic [6:0]  num_vec = '0;
   logic        mem_cen, fifo_rd, mac_valid, busy, done;
   logic [10:0] mem_addr;
   logic [31:0] mem_rdata = '0, fifo_in;
   logic [7:0]  fifo_wr;
   logic        fifo_full = 0, fifo_valid = 0, mac_ready = 1;

   ififo_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_vec(num_vec),
      .mem_cen(mem_cen), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .fifo_in(fifo_in),
      .fifo_wr(fifo_wr), .fifo_full(fifo_full), .fifo_valid(fifo_valid), .fifo_rd(fifo_rd),
      .mac_ready(mac_ready), .mac_valid(mac_valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   int cyc = 0, t0 = 0, full_from = 0, full_len = 0, rdy_mode = 0;
   int n_exp = 0, n_iss = 0, n_wr = 0, n_rd = 0, n_mv = 0, n_done = 0, done_cyc = -1;
   int iss_cyc[128], wr_cyc[128];
   logic [10:0] iss_adr[128];
   logic [10:0] exp_base = '0;
   logic        active = 0, prev_rd = 0;
   logic        s_cen = 1, s_wr = 0, s_rd = 0;
   logic [10:0] s_addr = '0;
   logic [31:0] s_in = '0;
   logic [31:0] q[$];

   function automatic logic [31:0] fdat(input logic [10:0] a);
      return {a, ~a, a[9:0]};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // environment: SRAM with 1-cycle read, FIFO occupancy, and stimulus for full/ready
   always @(posedge clk) begin
      int rel;
      #1;
      cyc++;
      if (!reset) q.delete();
      else begin
         if (!s_cen) mem_rdata = fdat(s_addr);
         if (s_wr) q.push_back(s_in);
         if (s_rd && q.size() > 0) void'(q.pop_front());
      end
      fifo_valid = q.size() > 0;
      rel = cyc - t0;
      fifo_full = full_len > 0 && rel >= full_from && rel < full_from + full_len;
      mac_ready = rdy_mode == 0 ? 1'b1 : (rel % 3 == 0);
   end

   // scoreboard: every cycle, outputs must obey the ordering and pacing rules
   always @(negedge clk) begin
      logic [10:0] ea;
      s_cen = mem_cen; s_addr = mem_addr; s_wr = fifo_wr != 0; s_in = fifo_in; s_rd = fifo_rd;
      if (!reset) begin
         chk("rst_outs", 64'({mem_cen, mem_addr, fifo_wr, fifo_in, fifo_rd, mac_valid, busy, done}),
             64'({1'b1, 55'b0}));
         prev_rd = 0;
      end else begin
         chk("mac_valid_lag", 64'(mac_valid), 64'(prev_rd));
         prev_rd = fifo_rd;
         if (mac_valid) n_mv++;
         if (!active) chk("idle_quiet", 64'({mem_cen, fifo_wr, fifo_rd, done}), 64'({1'b1, 10'b0}));
         else begin
            if (!mem_cen) begin
               ea = exp_base + 11'(n_iss);
               chk("iss_addr", 64'(mem_addr), 64'(ea));
               chk("iss_legal", 64'({fifo_full, n_iss < n_exp}), 64'(2'b01));
               if (n_iss < 128) begin iss_cyc[n_iss] = cyc; iss_adr[n_iss] = mem_addr; end
               n_iss++;
            end
            if (fifo_wr != 0) begin
               ea = exp_base + 11'(n_wr);
               chk("wr_mask", 64'(fifo_wr), 64'(8'hFF));
               chk("wr_data", 64'(fifo_in), 64'(fdat(ea)));
               chk("wr_full", 64'(fifo_full), 64'(0));
               if (n_wr < 128) wr_cyc[n_wr] = cyc;
               n_wr++;
            end
            if (fifo_rd) begin
               chk("rd_legal", 64'({mac_ready, fifo_valid, n_wr == n_exp, n_rd < n_exp}), 64'(4'hF));
               n_rd++;
            end
            if (done) begin
               chk("done_after_mv", 64'(n_mv), 64'(n_exp));
               chk("done_busy", 64'(busy), 64'(0));
               done_cyc = cyc;
               n_done++;
               active = 0;
            end else if (cyc > t0) chk("busy_hi", 64'(busy), 64'(1));
         end
      end
   end

   task automatic run_tile(input logic [10:0] b, input int nv, input int ff, input int fl,
                           input int rm, input int abuse, input int rst_rd);
      exp_base = b; n_exp = nv > 64 ? 64 : nv;
      full_from = ff; full_len = fl; rdy_mode = rm;
      @(posedge clk); #2;
      t0 = cyc; n_iss = 0; n_wr = 0; n_rd = 0; n_mv = 0; n_done = 0; done_cyc = -1;
      base_addr = b; num_vec = 7'(nv); start = 1; active = 1;
      for (int k = 0; k < 600; k++) begin
         @(posedge clk); #2;
         start = abuse > 0 && cyc == t0 + abuse;
         if (start) begin base_addr = 11'h3F0; num_vec = 7'd2; end
         if (rst_rd > 0 && n_rd >= rst_rd) begin reset = 0; active = 0; break; end
         if (n_done > 0) break;
      end
      start = 0;
      if (rst_rd > 0) chk("drain_reached", 64'(n_rd >= rst_rd), 64'(1));
      else begin
         chk("done_seen", 64'(n_done > 0), 64'(1));
         repeat (3) @(posedge clk);
         #2;
         chk("done_once", 64'(n_done), 64'(1));
         chk("n_iss", 64'(n_iss), 64'(n_exp));
         chk("n_wr", 64'(n_wr), 64'(n_exp));
         chk("n_rd", 64'(n_rd), 64'(n_exp));
         chk("n_mv", 64'(n_mv), 64'(n_exp));
      end
      full_len = 0; rdy_mode = 0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #2 reset = 1;
      // basic tile
      run_tile(11'h010, 8, 0, 0, 0, 0, 0);
      chk("basic_first_wr", 64'(wr_cyc[0] - t0), 64'(2));
      chk("basic_iss_span", 64'(iss_cyc[7] - iss_cyc[0]), 64'(7));
      chk("basic_adr0", 64'(iss_adr[0]), 64'(11'h010));
      chk("basic_adr7", 64'(iss_adr[7]), 64'(11'h017));
      // backpressure at the 4th write-back
      run_tile(11'h020, 8, 5, 3, 0, 0, 0);
      chk("bp_wr4_cycle", 64'(wr_cyc[3] - t0), 64'(8));
      chk("bp_iss5_cycle", 64'(iss_cyc[4] - t0), 64'(9));
      // drain stall with mac_ready 1,0,0,1,...
      run_tile(11'h040, 6, 0, 0, 1, 0, 0);
      // empty tile
      run_tile(11'h050, 0, 0, 0, 0, 0, 0);
      chk("zero_done_lat", 64'(done_cyc - t0), 64'(2));
      // clamp
      run_tile(11'h200, 100, 0, 0, 0, 0, 0);
      chk("clamp_64", 64'(n_wr), 64'(64));
      // address wrap
      run_tile(11'h7FE, 4, 0, 0, 0, 0, 0);
      chk("wrap_a0", 64'(iss_adr[0]), 64'(11'h7FE));
      chk("wrap_a1", 64'(iss_adr[1]), 64'(11'h7FF));
      chk("wrap_a2", 64'(iss_adr[2]), 64'(11'h000));
      chk("wrap_a3", 64'(iss_adr[3]), 64'(11'h001));
      // start during LOAD is ignored
      run_tile(11'h100, 6, 0, 0, 0, 3, 0);
      chk("abuse_adr5", 64'(iss_adr[5]), 64'(11'h105));
      // reset mid-DRAIN
      run_tile(11'h300, 16, 0, 0, 1, 0, 3);
      #1;
      chk("rst_async", 64'({mem_cen, mem_addr, fifo_wr, fifo_in, fifo_rd, mac_valid, busy, done}),
          64'({1'b1, 55'b0}));
      repeat (2) @(posedge clk);
      #2 reset = 1;
      repeat (30) @(posedge clk);
      #2;
      chk("rst_no_done", 64'(n_done), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ififo_ctrl.md
Name: ififo_ctrl

Overview:
- Sequencer for the weight input FIFO bank (8 rows, one column of weights per row).
- LOAD phase: fetches `num_vec` weight vectors from the weight SRAM, starting at a base address, and writes them into all FIFO rows in parallel.
- DRAIN phase: pops the same number of vectors toward the west edge of the MAC array, paced by the array's ready signal.
- Signals completion with a one-cycle done pulse so the top-level scheduler can chain tiles.

Parameters:
- row, 8: FIFO rows; width of `fifo_wr`.
- bw, 4: weight bit width per row.
- addr_w, 11: SRAM address width.
- rd_lat, 1: cycles from `fifo_rd` to valid FIFO output; sets `mac_valid` delay.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  begin a tile; sampled only in IDLE.
- base_addr  in  addr_w  first SRAM address; latched on accepted start.
- num_vec  in  7  vectors per tile; latched on accepted start; values 65..127 clamp to 64.
- mem_cen  out  1  SRAM chip enable, active-low.
- mem_addr  out  addr_w  SRAM read address.
- mem_rdata  in  row*bw  SRAM read data, valid 1 cycle after `mem_cen`=0.
- fifo_in  out  row*bw  data to FIFO bank.
- fifo_wr  out  row  per-row write strobes; all bits equal.
- fifo_full  in  1  OR of row full flags.
- fifo_valid  in  1  all rows non-empty.
- fifo_rd  out  1  pop all rows.
- mac_ready  in  1  MAC array accepts a vector this cycle.
- mac_valid  out  1  `fifo_rd` delayed by `rd_lat` cycles.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at tile end.

Behaviour:
- Reset (`reset`=0, asynchronous):
  - State goes to IDLE; all counters, skid register and delay line clear.
  - Outputs: `mem_cen`=1, `mem_addr`=0, `fifo_wr`=0, `fifo_in`=0, `fifo_rd`=0, `mac_valid`=0, `busy`=0, `done`=0.
  - Reset mid-tile abandons the tile; no done pulse.
- States: IDLE, LOAD, FLUSH, DRAIN, DONE.
- IDLE:
  - `start`=1 latches `base_addr` and `num_vec` (clamped).
  - Goes to LOAD, or to DONE directly if `num_vec`=0.
  - `start` in any other state is ignored.
- LOAD, read issue:
  - Issue when `fifo_full`=0, the skid register is empty, and `iss_cnt` < `num_vec`.
  - On issue: `mem_cen`=0, `mem_addr` = base + `iss_cnt`, then `iss_cnt`++.
  - Address arithmetic is modulo 2^addr_w (wraps).
- LOAD, write-back (cycle after each issue):
  - If `fifo_full`=0: `fifo_wr` = all ones, `fifo_in` = `mem_rdata`, `wr_cnt`++.
  - Else: `mem_rdata` is captured in the 1-entry skid register. It is written (and `wr_cnt`++) on the first later cycle with `fifo_full`=0.
  - No data is ever dropped.
- LOAD → FLUSH when `iss_cnt` reaches `num_vec`.
- FLUSH:
  - Completes the outstanding write-back or skid write.
  - Goes to DRAIN when `wr_cnt` = `num_vec`.
- DRAIN:
  - `fifo_rd` = `mac_ready` & `fifo_valid` & (`rd_cnt` < `num_vec`), combinational from registered state; each pop increments `rd_cnt`.
  - `mac_valid` is `fifo_rd` through an `rd_lat`-stage shift register.
  - Goes to DONE when `rd_cnt` = `num_vec` and the delay line is empty.
- DONE: `done`=1 for exactly one cycle, then IDLE. `busy` is 1 throughout LOAD..DONE.
- Simultaneous events:
  - A write-back and a new issue may occur in the same cycle (full throughput: 1 vector/cycle when never full).
  - `fifo_full` rising exactly at write-back diverts that word to the skid register.
- Latency: `start` to first `fifo_wr` = 2 cycles, assuming `fifo_full`=0.

Test Plan:
- Basic tile: reset, `start` with base=0x010, `num_vec`=8, `fifo_full`=0, `mac_ready`=1 → `mem_addr` 0x010..0x017 on 8 consecutive cycles; 8 `fifo_wr` pulses (0xFF) with matching data; 8 `fifo_rd`; `mac_valid` lags each `fifo_rd` by 1 cycle; single `done` pulse; `busy` falls with it.
- Backpressure: force `fifo_full`=1 for 3 cycles at the cycle of the 4th write-back → word 4 held in skid, no issue during the stall, written when full drops; total writes = 8; SRAM data order preserved.
- Drain stall: `mac_ready` toggles 1,0,0,1,... → `fifo_rd` only when `mac_ready`=1; exactly `num_vec` pops; `done` only after the last `mac_valid`.
- Edges:
  - `num_vec`=0 → `done` 2 cycles after `start`, no memory or FIFO activity.
  - `num_vec`=100 → exactly 64 vectors.
  - base=0x7FE, `num_vec`=4 → addresses 0x7FE, 0x7FF, 0x000, 0x001.
- Reset/start abuse: assert `reset`=0 mid-DRAIN → all outputs 0 immediately, IDLE, no `done`. A `start` pulsed during LOAD is ignored (counters unchanged).
